// File: rtl/pll_pkg.sv
// Shared types and constants for the PI loop filter and its lock detector.
package pll_pkg;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1
  } lf_state_e;

  function automatic longint center_of(input int cc_w);
    return 64'sd1 <<< (cc_w - 1);
  endfunction

  function automatic longint acc_min_of(input int cc_w, input int frac_w);
    return -(center_of(cc_w) <<< frac_w);
  endfunction

  function automatic longint acc_max_of(input int cc_w, input int frac_w);
    return ((64'sd1 <<< cc_w) - 64'sd1 - center_of(cc_w)) <<< frac_w;
  endfunction

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input logic signed [63:0] lo,
                                                    input logic signed [63:0] hi);
    logic signed [63:0] r;
    if (v < lo) begin
      r = lo;
    end else if (v > hi) begin
      r = hi;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/pll_lock_detect.sv
// Lock detector: counts consecutive qualifying error samples and gear-shifts
// between ACQUIRE and TRACK.
module pll_lock_detect
  import pll_pkg::*;
#(
  parameter int ERR_W         = 8,
  parameter int LOCK_THRESH   = 2,
  parameter int UNLOCK_THRESH = 8,
  parameter int LOCK_CNT      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_en,
  input  logic signed [ERR_W-1:0] error,
  output lf_state_e               state,
  output logic                    locked
);

  localparam int CNT_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [ERR_W:0]   LOCK_T   = (ERR_W + 1)'(LOCK_THRESH);
  localparam logic [ERR_W:0]   UNLOCK_T = (ERR_W + 1)'(UNLOCK_THRESH);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [ERR_W:0]   err_ext;
  logic [ERR_W:0]   abs_e;
  logic             qualify;
  lf_state_e        state_other;

  // One extra bit so the most negative input has a representable magnitude.
  always_comb begin
    err_ext = {error[ERR_W-1], error};
    if (err_ext[ERR_W]) begin
      abs_e = -err_ext;
    end else begin
      abs_e = err_ext;
    end
    cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    case (state)
      ACQUIRE: begin
        qualify     = (abs_e <= LOCK_T);
        state_other = TRACK;
      end
      TRACK: begin
        qualify     = (abs_e > UNLOCK_T);
        state_other = ACQUIRE;
      end
      default: begin
        qualify     = 1'b0;
        state_other = ACQUIRE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ACQUIRE;
      locked <= 1'b0;
      cnt    <= '0;
    end else if (sample_en) begin
      if (!qualify) begin
        cnt <= '0;
      end else if (cnt_inc == CNT_LIM) begin
        state  <= state_other;
        locked <= (state_other == TRACK);
        cnt    <= '0;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: rtl/pi_loop_filter.sv
// Proportional-integral loop filter producing the DCO control code, with a
// saturating fractional integrator, output clamp and lock-driven gain shift.
module pi_loop_filter
  import pll_pkg::*;
#(
  parameter int ERR_W         = 8,
  parameter int CC_W          = 8,
  parameter int FRAC_W        = 8,
  parameter int KP_ACQ_SHIFT  = 1,
  parameter int KI_ACQ_SHIFT  = 3,
  parameter int KP_TRK_SHIFT  = 3,
  parameter int KI_TRK_SHIFT  = 6,
  parameter int LOCK_THRESH   = 2,
  parameter int UNLOCK_THRESH = 8,
  parameter int LOCK_CNT      = 16
) (
  input  logic                    gen_clk_i,
  input  logic                    reset_i,
  input  logic                    error_valid_i,
  input  logic signed [ERR_W-1:0] error_i,
  input  logic                    hold_i,
  output logic [CC_W-1:0]         dco_cc_o,
  output logic                    locked_o,
  output logic [1:0]              state_o
);

  localparam int ACC_W = CC_W + FRAC_W + 2;
  localparam logic signed [ACC_W-1:0] ACC_MIN   = ACC_W'(acc_min_of(CC_W, FRAC_W));
  localparam logic signed [ACC_W-1:0] ACC_MAX   = ACC_W'(acc_max_of(CC_W, FRAC_W));
  localparam logic signed [ACC_W-1:0] CENTER_S  = ACC_W'(center_of(CC_W) <<< FRAC_W);
  localparam logic signed [ACC_W-1:0] CC_MAX_S  = ACC_W'((64'sd1 <<< CC_W) - 64'sd1);
  localparam logic [CC_W-1:0]         CC_MAX    = {CC_W{1'b1}};
  localparam logic [CC_W-1:0]         CENTER_CC = CC_W'(center_of(CC_W));

  logic                    sample_en;
  lf_state_e               state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_n;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] e_ext;
  logic signed [ACC_W-1:0] e_s;
  logic signed [ACC_W-1:0] i_term;
  logic signed [ACC_W-1:0] p_term;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] q;
  logic signed [63:0]      sat_tmp;
  logic [CC_W-1:0]         cc_n;

  assign sample_en = error_valid_i && !hold_i;
  assign state_o   = state;

  // PI datapath; gains follow the registered state, so a switch is bumpless.
  always_comb begin
    e_ext = ACC_W'(error_i);
    e_s   = e_ext <<< FRAC_W;
    if (state == TRACK) begin
      i_term = e_s >>> KI_TRK_SHIFT;
      p_term = e_s >>> KP_TRK_SHIFT;
    end else begin
      i_term = e_s >>> KI_ACQ_SHIFT;
      p_term = e_s >>> KP_ACQ_SHIFT;
    end
    acc_sum = acc + i_term;
    sat_tmp = sat_signed(64'(acc_sum), 64'(ACC_MIN), 64'(ACC_MAX));
    acc_n   = sat_tmp[ACC_W-1:0];
    sum     = CENTER_S + acc_n + p_term;
    q       = sum >>> FRAC_W;
    if (q[ACC_W-1]) begin
      cc_n = '0;
    end else if (q > CC_MAX_S) begin
      cc_n = CC_MAX;
    end else begin
      cc_n = q[CC_W-1:0];
    end
  end

  always_ff @(posedge gen_clk_i) begin
    if (reset_i) begin
      acc      <= '0;
      dco_cc_o <= CENTER_CC;
    end else if (sample_en) begin
      acc      <= acc_n;
      dco_cc_o <= cc_n;
    end
  end

  pll_lock_detect #(
    .ERR_W        (ERR_W),
    .LOCK_THRESH  (LOCK_THRESH),
    .UNLOCK_THRESH(UNLOCK_THRESH),
    .LOCK_CNT     (LOCK_CNT)
  ) u_lock (
    .clk      (gen_clk_i),
    .reset    (reset_i),
    .sample_en(sample_en),
    .error    (error_i),
    .state    (state),
    .locked   (locked_o)
  );

endmodule

// File: tb/tb_pi_loop_filter.sv
// Directed test of pi_loop_filter at default parameters with hand-computed
// expected control codes and lock behaviour.
module tb_pi_loop_filter;

  logic              gen_clk_i = 1'b0;
  logic              reset_i = 1'b1;
  logic              error_valid_i = 1'b0;
  logic signed [7:0] error_i = 8'sd0;
  logic              hold_i = 1'b0;
  logic [7:0]        dco_cc_o;
  logic              locked_o;
  logic [1:0]        state_o;

  int n_checks = 0;
  int n_fail   = 0;

  pi_loop_filter dut (
    .gen_clk_i    (gen_clk_i),
    .reset_i      (reset_i),
    .error_valid_i(error_valid_i),
    .error_i      (error_i),
    .hold_i       (hold_i),
    .dco_cc_o     (dco_cc_o),
    .locked_o     (locked_o),
    .state_o      (state_o)
  );

  always #5 gen_clk_i = ~gen_clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input int e, input logic h, input logic r);
    error_valid_i = v;
    error_i       = 8'(e);
    hold_i        = h;
    reset_i       = r;
    @(posedge gen_clk_i);
    #1;
  endtask

  task automatic run(input int n, input int e);
    for (int i = 0; i < n; i++) step(1'b1, e, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset with a valid error present
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 10, 1'b0, 1'b1);
      chk("rst_cc", 32'(dco_cc_o), 32'd128);
      chk("rst_locked", 32'(locked_o), 32'd0);
      chk("rst_state", 32'(state_o), 32'd0);
    end

    // Step response, ACQUIRE gains
    step(1'b1, 10, 1'b0, 1'b0); chk("step1", 32'(dco_cc_o), 32'd134);
    step(1'b1, 10, 1'b0, 1'b0); chk("step2", 32'(dco_cc_o), 32'd135);
    step(1'b1, 10, 1'b0, 1'b0); chk("step3", 32'(dco_cc_o), 32'd136);
    step(1'b1, 10, 1'b0, 1'b0); chk("step4", 32'(dco_cc_o), 32'd138);
    step(1'b0, 99, 1'b0, 1'b0); chk("novalid1", 32'(dco_cc_o), 32'd138);
    step(1'b1, 10, 1'b0, 1'b0); chk("step5", 32'(dco_cc_o), 32'd139);
    step(1'b0, 99, 1'b0, 1'b0); chk("novalid2", 32'(dco_cc_o), 32'd139);
    step(1'b1, 10, 1'b0, 1'b0); chk("step6", 32'(dco_cc_o), 32'd140);

    // Five lock-qualifying samples, then hold with a large valid error
    run(5, 0);
    chk("zero_err", 32'(dco_cc_o), 32'd135);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 50, 1'b1, 1'b0);
      chk("hold_cc", 32'(dco_cc_o), 32'd135);
    end
    chk("hold_state", 32'(state_o), 32'd0);

    // Release: acc resumes from where it was, lock count continues from 5
    step(1'b1, 1, 1'b0, 1'b0);
    chk("resume_cc", 32'(dco_cc_o), 32'd136);
    run(9, 1);
    chk("pre_lock_cc", 32'(dco_cc_o), 32'd137);
    chk("pre_lock", 32'(locked_o), 32'd0);
    run(1, 1);
    chk("lock", 32'(locked_o), 32'd1);
    chk("lock_state", 32'(state_o), 32'd1);

    // Unlock run in TRACK, interrupted once by a small error
    step(1'b1, 20, 1'b0, 1'b0);
    chk("trk_gain_cc", 32'(dco_cc_o), 32'd139);
    run(9, 20);
    run(1, 5);
    run(15, 20);
    chk("unlock_pre", 32'(locked_o), 32'd1);
    run(1, 20);
    chk("unlock", 32'(locked_o), 32'd0);
    chk("unlock_state", 32'(state_o), 32'd0);
    chk("unlock_cc", 32'(dco_cc_o), 32'd147);

    // Windup and saturation
    step(1'b1, 10, 1'b0, 1'b1);
    chk("rst2_cc", 32'(dco_cc_o), 32'd128);
    chk("rst2_state", 32'(state_o), 32'd0);
    run(200, 127);
    chk("sat_hi", 32'(dco_cc_o), 32'd255);
    run(1, -1);
    chk("recover", 32'(dco_cc_o), 32'd254);

    // Lock, then reset together with hold while in TRACK
    step(1'b1, 0, 1'b0, 1'b1);
    run(15, 0);
    chk("lock2_pre", 32'(locked_o), 32'd0);
    run(1, 0);
    chk("lock2", 32'(locked_o), 32'd1);
    step(1'b1, 10, 1'b1, 1'b1);
    chk("rsthold_cc", 32'(dco_cc_o), 32'd128);
    chk("rsthold_lock", 32'(locked_o), 32'd0);
    chk("rsthold_state", 32'(state_o), 32'd0);
    step(1'b1, 10, 1'b0, 1'b0);
    chk("post_rst_cc", 32'(dco_cc_o), 32'd134);

    // Relock, then the most negative error must count toward unlock
    run(15, 0);
    chk("lock3_pre", 32'(locked_o), 32'd0);
    chk("lock3_cc", 32'(dco_cc_o), 32'd129);
    run(1, 0);
    chk("lock3", 32'(locked_o), 32'd1);
    run(15, -128);
    chk("neg_pre", 32'(locked_o), 32'd1);
    chk("neg_pre_cc", 32'(dco_cc_o), 32'd83);
    run(1, -128);
    chk("neg_unlock", 32'(locked_o), 32'd0);
    chk("neg_unlock_cc", 32'(dco_cc_o), 32'd81);
    run(10, -128);
    chk("sat_lo", 32'(dco_cc_o), 32'd0);
    chk("sat_lo_state", 32'(state_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
